// File: rtl/dcache_pkg.sv
// Purpose : shared constants and types for the direct-mapped write-through data cache.
// Latency : n/a (types only).
// Backpressure: n/a (types only).
package dcache_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int NUM_LINES = 16;
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int TAG_W     = ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:IDX_W];
  endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// Purpose : bundles the CPU-side request/response and the backing-memory req/ack signals.
// Latency : n/a (wiring only).
// Backpressure: cpu_ready stalls the CPU; memory stalls the cache by delaying mem_ack.
// Modports: slave  = cache view (takes CPU requests, drives memory requests)
//           master = environment view (CPU + backing memory)
interface dcache_responder_if;
  import dcache_pkg::*;

  logic              cpu_req_valid;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_resp_valid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_resp_valid, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_resp_valid, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_line_array.sv
// Purpose : NUM_LINES x line_t storage, one combinational read port, one write port.
// Latency : read is combinational; write lands on the next rising edge.
// Backpressure: none; the caller owns all sequencing.
// Ports   : i_clk, i_rst_n (clears valid bits only), i_rd_idx/o_rd_line,
//           i_wr_en/i_wr_idx/i_wr_line.
module dcache_line_array
  import dcache_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output line_t            o_rd_line,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  line_t            i_wr_line
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [DATA_W-1:0]    r_data [NUM_LINES];

  // Only the valid bits need reset; stale tag/data behind a cleared valid is harmless.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= i_wr_line.valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_line.tag;
      r_data[i_wr_idx] <= i_wr_line.data;
    end
  end

  always_comb begin
    o_rd_line       = '0;
    o_rd_line.valid = r_valid[i_rd_idx];
    o_rd_line.tag   = r_tag[i_rd_idx];
    o_rd_line.data  = r_data[i_rd_idx];
  end

endmodule

// File: rtl/dcache_responder.sv
// Purpose : direct-mapped, write-through, no-write-allocate data cache in front of slow memory.
// Latency : load hit responds next cycle; miss/store respond the cycle after mem_ack.
// Backpressure: cpu_ready is low while a miss or write-through is outstanding at memory.
// Ports   : i_clk, i_rst_n, bus (dcache_responder_if.slave: CPU req/resp + memory req/ack).
//           With DCACHE_PERF_EN defined: o_hit_count, o_miss_count (saturating load counters).
module dcache_responder
  import dcache_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  dcache_responder_if.slave bus
`ifdef DCACHE_PERF_EN
  ,
  output logic [15:0]      o_hit_count,
  output logic [15:0]      o_miss_count
`endif
);

  state_t            r_state;
  logic              r_resp_vld;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  line_t             w_rd_line;
  line_t             w_wr_line;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_accept;
  logic              w_hit;
  logic              w_fill;

  assign w_accept = bus.cpu_req_valid && (r_state == IDLE);
  assign w_hit    = w_rd_line.valid && (w_rd_line.tag == addr_tag(bus.cpu_addr));
  assign w_fill   = (r_state == RD_MISS) && bus.mem_ack;

  // The single write port is shared: a fill only happens in RD_MISS, a store
  // update only on acceptance in IDLE, so the two never collide.
  always_comb begin
    w_wr_en   = w_fill || (w_accept && bus.cpu_we && w_hit);
    w_wr_idx  = addr_idx(bus.cpu_addr);
    w_wr_line = '{valid: 1'b1, tag: addr_tag(bus.cpu_addr), data: bus.cpu_wdata};
    if (r_state == RD_MISS) begin
      w_wr_idx  = addr_idx(r_mem_addr);
      w_wr_line = '{valid: 1'b1, tag: addr_tag(r_mem_addr), data: bus.mem_rdata};
    end
  end

  dcache_line_array u_lines (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rd_idx  (addr_idx(bus.cpu_addr)),
    .o_rd_line (w_rd_line),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_wr_idx),
    .i_wr_line (w_wr_line)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_resp_vld  <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_resp_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (bus.cpu_we) begin
              r_mem_addr  <= bus.cpu_addr;
              r_mem_wdata <= bus.cpu_wdata;
              r_state     <= WR_THRU;
            end else if (w_hit) begin
              r_resp_vld  <= 1'b1;
              r_rdata     <= w_rd_line.data;
            end else begin
              r_mem_addr  <= bus.cpu_addr;
              r_state     <= RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (bus.mem_ack) begin
            r_resp_vld <= 1'b1;
            r_rdata    <= bus.mem_rdata;
            r_state    <= IDLE;
          end
        end
        WR_THRU: begin
          if (bus.mem_ack) begin
            r_resp_vld <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory-side controls decode straight from the registered state so they
  // drop the instant reset is asserted.
  assign bus.cpu_ready      = (r_state == IDLE);
  assign bus.cpu_resp_valid = r_resp_vld;
  assign bus.cpu_rdata      = r_rdata;
  assign bus.mem_req        = (r_state != IDLE);
  assign bus.mem_we         = (r_state == WR_THRU);
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wdata      = r_mem_wdata;

`ifdef DCACHE_PERF_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_accept && !bus.cpu_we) begin
      if (w_hit && (r_hit_count != 16'hFFFF)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (!w_hit && (r_miss_count != 16'hFFFF)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Purpose : directed self-checking bench for dcache_responder (plus counters under DCACHE_PERF_EN).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpressure: the bench plays backing memory, acking after a chosen number of cycles.
module tb_dcache_responder;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_responder_if bus();

  int checks = 0;
  int errors = 0;

`ifdef DCACHE_PERF_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  dcache_responder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
`ifdef DCACHE_PERF_EN
    ,
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for exactly one accepting edge; returns on the next falling edge.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    check("ready_before_req", {15'd0, bus.cpu_ready}, 16'd1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_we        = we;
    bus.cpu_addr      = addr;
    bus.cpu_wdata     = wdata;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
  endtask

  task automatic load_hit(input logic [7:0] addr, input logic [7:0] exp);
    issue(1'b0, addr, 8'h00);
    check("hit_resp_vld", {15'd0, bus.cpu_resp_valid}, 16'd1);
    check("hit_rdata", {8'd0, bus.cpu_rdata}, {8'd0, exp});
    check("hit_no_mem_req", {15'd0, bus.mem_req}, 16'd0);
    @(negedge clk);
    check("hit_resp_pulse_end", {15'd0, bus.cpu_resp_valid}, 16'd0);
  endtask

  // Acts as memory for an outstanding miss/write: checks the held request,
  // acks on the delay-th cycle, then checks the response pulse.
  task automatic serve(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                       input int delay, input logic [7:0] rdata);
    for (int k = 0; k < delay; k++) begin
      check("mem_req_held", {15'd0, bus.mem_req}, 16'd1);
      check("mem_addr_held", {8'd0, bus.mem_addr}, {8'd0, addr});
      check("mem_we_held", {15'd0, bus.mem_we}, {15'd0, we});
      if (we) check("mem_wdata_held", {8'd0, bus.mem_wdata}, {8'd0, wdata});
      check("ready_low_busy", {15'd0, bus.cpu_ready}, 16'd0);
      check("no_early_resp", {15'd0, bus.cpu_resp_valid}, 16'd0);
      if (k == delay - 1) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
      end
      @(negedge clk);
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    check("resp_after_ack", {15'd0, bus.cpu_resp_valid}, 16'd1);
    check("mem_req_drop", {15'd0, bus.mem_req}, 16'd0);
    check("ready_after_ack", {15'd0, bus.cpu_ready}, 16'd1);
    if (!we) check("miss_rdata", {8'd0, bus.cpu_rdata}, {8'd0, rdata});
    @(negedge clk);
    check("resp_pulse_end", {15'd0, bus.cpu_resp_valid}, 16'd0);
    check("no_rerequest", {15'd0, bus.mem_req}, 16'd0);
  endtask

  initial begin
    bus.cpu_req_valid = 1'b0;
    bus.cpu_we        = 1'b0;
    bus.cpu_addr      = 8'h00;
    bus.cpu_wdata     = 8'h00;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = 8'h00;

    // Reset values while held in reset.
    #12;
    check("rst_resp_vld", {15'd0, bus.cpu_resp_valid}, 16'd0);
    check("rst_rdata", {8'd0, bus.cpu_rdata}, 16'd0);
    check("rst_mem_req", {15'd0, bus.mem_req}, 16'd0);
    check("rst_mem_we", {15'd0, bus.mem_we}, 16'd0);
    check("rst_mem_addr", {8'd0, bus.mem_addr}, 16'd0);
    check("rst_mem_wdata", {8'd0, bus.mem_wdata}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {15'd0, bus.cpu_ready}, 16'd1);

    // Stray ack while idle must do nothing.
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'hEE;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("idle_ack_no_resp", {15'd0, bus.cpu_resp_valid}, 16'd0);
    check("idle_ack_no_req", {15'd0, bus.mem_req}, 16'd0);
    @(negedge clk);

    // Cold load miss, then hit.
    issue(1'b0, 8'h10, 8'h00);
    serve(1'b0, 8'h10, 8'h00, 3, 8'hA5);
    load_hit(8'h10, 8'hA5);

    // Four back-to-back hits.
    bus.cpu_req_valid = 1'b1;
    bus.cpu_we        = 1'b0;
    bus.cpu_addr      = 8'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_resp_vld", {15'd0, bus.cpu_resp_valid}, 16'd1);
      check("b2b_rdata", {8'd0, bus.cpu_rdata}, 16'h00A5);
      check("b2b_ready", {15'd0, bus.cpu_ready}, 16'd1);
      if (i == 3) bus.cpu_req_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_end", {15'd0, bus.cpu_resp_valid}, 16'd0);

    // Store hit writes through and updates the line.
    issue(1'b1, 8'h10, 8'h3C);
    serve(1'b1, 8'h10, 8'h3C, 2, 8'h00);
    check("store_keeps_rdata", {8'd0, bus.cpu_rdata}, 16'h00A5);
    load_hit(8'h10, 8'h3C);

    // Store miss does not allocate; following load misses.
    issue(1'b1, 8'h22, 8'h5A);
    serve(1'b1, 8'h22, 8'h5A, 1, 8'h00);
    issue(1'b0, 8'h22, 8'h00);
    serve(1'b0, 8'h22, 8'h00, 2, 8'h77);

    // Aliasing on index 5.
    issue(1'b0, 8'h05, 8'h00);
    serve(1'b0, 8'h05, 8'h00, 1, 8'h11);
    issue(1'b0, 8'h15, 8'h00);
    serve(1'b0, 8'h15, 8'h00, 2, 8'h22);
    issue(1'b0, 8'h05, 8'h00);
    serve(1'b0, 8'h05, 8'h00, 1, 8'h11);
    check("rdata_holds_idle", {8'd0, bus.cpu_rdata}, 16'h0011);

`ifdef DCACHE_PERF_EN
    check("perf_hits", hit_count, 16'd6);
    check("perf_misses", miss_count, 16'd5);
`endif

    // Reset in the middle of a read miss.
    issue(1'b0, 8'h33, 8'h00);
    check("pre_rst_mem_req", {15'd0, bus.mem_req}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_req", {15'd0, bus.mem_req}, 16'd0);
    check("midrst_resp_vld", {15'd0, bus.cpu_resp_valid}, 16'd0);
`ifdef DCACHE_PERF_EN
    check("perf_rst_hits", hit_count, 16'd0);
    check("perf_rst_misses", miss_count, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 8'h05, 8'h00);
    serve(1'b0, 8'h05, 8'h00, 1, 8'h11);
    load_hit(8'h05, 8'h11);

`ifdef DCACHE_PERF_EN
    check("perf_post_rst_miss", miss_count, 16'd1);
    check("perf_post_rst_hit", hit_count, 16'd1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_we        = 1'b0;
    bus.cpu_addr      = 8'h05;
    repeat (65540) @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    @(negedge clk);
    check("perf_hit_saturate", hit_count, 16'hFFFF);
    check("perf_miss_unchanged", miss_count, 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Answers the pipeline MEM stage's load/store requests (8-bit address, 8-bit data) and forwards misses and all writes to the backing `storage` data memory over a req/ack interface.
- Converts the fixed-latency `storage` access into a stallable responder, so the cached processor can tolerate slow memory.

Parameters:
- ADDR_W, 8, byte address width (matches data memory depth of 256).
- DATA_W, 8, data width.
- NUM_LINES, 16, cache lines of one byte each; power of two; IDX_W = log2(NUM_LINES), TAG_W = ADDR_W - IDX_W.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req_valid  in  1  MEM stage request valid
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  byte address (ALU result)
- cpu_wdata  in  DATA_W  store data
- cpu_ready  out  1  request accepted when cpu_req_valid && cpu_ready
- cpu_resp_valid  out  1  one-cycle pulse: load data valid / store complete
- cpu_rdata  out  DATA_W  load data, valid with cpu_resp_valid
- mem_req  out  1  backing-memory request
- mem_we  out  1  backing write
- mem_addr  out  ADDR_W  backing address
- mem_wdata  out  DATA_W  backing write data
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; all valid bits cleared.
  - cpu_resp_valid = 0, cpu_rdata = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_ready = 1 once rst_n is released.
- Address split: index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W]. Hit = valid[index] && tag match.
- FSM states: IDLE, RD_MISS, WR_THRU.
  - cpu_ready = (state == IDLE).
  - mem_req = (state != IDLE), decoded from the registered state.
  - mem_we = (state == WR_THRU).
- Load hit (accepted cycle N):
  - Stays in IDLE.
  - cpu_resp_valid = 1 at N+1 with line data.
  - Back-to-back hits sustain one per cycle.
- Load miss (accepted N):
  - IDLE -> RD_MISS; mem_addr latched at N, mem_req high from N+1.
  - On the mem_ack cycle M: line written with {valid = 1, tag, mem_rdata}, state -> IDLE.
  - cpu_resp_valid = 1 and cpu_rdata = mem_rdata at M+1.
- Store (accepted N):
  - If hit, line data is updated at N; if miss, the cache is unchanged.
  - IDLE -> WR_THRU; mem_addr/mem_wdata latched at N.
  - On mem_ack at M: -> IDLE, cpu_resp_valid at M+1.
- mem_addr, mem_wdata and mem_we are held stable while mem_req is high.
- mem_ack while IDLE is ignored.
- A new request may be accepted in cycle M+1, the same cycle the previous response pulses.
- cpu_rdata holds its last value when cpu_resp_valid = 0.
- Reset mid-transaction: mem_req drops immediately and the line is not filled. Memory must tolerate an abandoned request.
- Wrap-around/aliasing: addresses 0x05 and 0x15 share index 5; each evicts the other.

Optional Feature:
- Macro: DCACHE_PERF_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Incremented on each accepted load hit / load miss respectively.
  - Saturate at 0xFFFF; reset to 0.
  - Stores are not counted.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Package dcache_pkg:
  - ADDR_W, DATA_W, NUM_LINES, IDX_W, TAG_W constants.
  - state_t enum {IDLE, RD_MISS, WR_THRU}.
  - line_t struct {valid, tag, data}.
- Sub-module dcache_line_array: NUM_LINES x line_t storage with one combinational read port, one write port, and an async clear of valid bits. The FSM and the handshake stay in dcache_responder.

Test Plan:
- Cold load 0x10, memory[0x10] = 0xA5, ack after 3 cycles -> mem_req/addr 0x10 held for 3 cycles, cpu_resp_valid one cycle after ack with rdata 0xA5, no re-request.
- Second load of 0x10 -> no mem_req, resp at N+1 with 0xA5.
- Four consecutive hits -> four consecutive response pulses, cpu_ready held high throughout.
- Store 0x10 = 0x3C (hit) -> mem_we = 1, addr 0x10, wdata 0x3C until ack; subsequent load 0x10 hits with 0x3C.
- Store to 0x22 (miss), then load 0x22 -> store goes write-through only; the load misses and reads from memory.
- Alias test: load 0x05 then 0x15 then 0x05 -> three misses. Also: assert rst_n low during RD_MISS -> mem_req and cpu_resp_valid drop at once, next load 0x05 misses.
- With DCACHE_PERF_EN: sequence above -> hit_count and miss_count match the scoreboard. Force 65 536 hits -> hit_count saturates at 0xFFFF.
